stump_alu_seq: RTL

//  Registered, parametrised successor to the Stump combinational ALU: shift stage on operand A, then
//  ADD/ADC/SUB/SBC/AND/OR/XOR, plus optional iterative multiply. Sits between decode and writeback.

---
 rtl/stump_alu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/stump_alu_seq.sv
// Registered Stump ALU: 1-bit shift on A, then ADD/ADC/SUB/SBC/AND/OR/XOR, one-slot output with valid/ready.
// Define STUMP_ALU_MUL_EN for an iterative WIDTH-cycle unsigned MUL on func 110; otherwise func 110 is MOV.
module stump_alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic [2:0]       func,
  input  logic [1:0]       shift,
  input  logic             c_in,
  input  logic             flag_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             busy
);
  localparam logic [2:0] F_AND = 3'b100;
  localparam logic [2:0] F_OR  = 3'b101;
  localparam logic [2:0] F_MUL = 3'b110;
  localparam logic [2:0] F_XOR = 3'b111;

  if (WIDTH < 4 || (2 ** CNT_W) <= WIDTH) begin : g_bad_param
    $error("stump_alu_seq: requires WIDTH >= 4 and 2**CNT_W > WIDTH");
  end

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_idle;
  logic             w_accept;
  logic             w_start_mul;
  logic             w_mul_done;
  logic             w_mul_fwen;
  logic [WIDTH-1:0] w_mul_res;
  logic [3:0]       w_mul_nzvc;

  logic [WIDTH-1:0] w_a_sh;
  logic             w_csh;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic             w_c;
  logic [3:0]       w_nzvc;

  always_comb begin
    w_a_sh = operand_A;
    w_csh  = operand_A[0];
    case (shift)
      2'b01:   w_a_sh = {operand_A[WIDTH-1], operand_A[WIDTH-1:1]};
      2'b10:   w_a_sh = {operand_A[0], operand_A[WIDTH-1:1]};
      2'b11:   w_a_sh = {c_in, operand_A[WIDTH-1:1]};
      default: w_csh  = c_in;
    endcase
  end

  // Carry into the adder: ADD 0, ADC c_in, SUB 1, SBC c_in (subtracts use ~B).
  assign w_cin = func[0] ? c_in : func[1];

  always_comb begin
    w_sum = '0;
    w_res = w_a_sh;
    w_v   = 1'b0;
    w_c   = w_csh;
    case (func)
      F_AND: w_res = w_a_sh & operand_B;
      F_OR:  w_res = w_a_sh | operand_B;
      F_XOR: w_res = w_a_sh ^ operand_B;
      F_MUL: w_res = w_a_sh;
      default: begin
        w_sum = {1'b0, w_a_sh} + {1'b0, (func[1] ? ~operand_B : operand_B)} + {{WIDTH{1'b0}}, w_cin};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a_sh[WIDTH-1] == (operand_B[WIDTH-1] ^ func[1])) &
                (w_res[WIDTH-1] != w_a_sh[WIDTH-1]);
      end
    endcase
  end

  assign w_nzvc   = {w_res[WIDTH-1], ~|w_res, w_v, w_c};
  assign in_ready = w_idle & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

`ifdef STUMP_ALU_MUL_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MULT = 1'b1;

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_fwen;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_idle      = (r_state == S_IDLE);
  assign w_start_mul = w_accept & (func == F_MUL);
  assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done  = (r_state == S_MULT) & (r_cnt == CNT_W'(WIDTH - 1));
  assign w_mul_fwen  = r_fwen;
  assign w_mul_res   = w_acc_nxt[WIDTH-1:0];
  assign w_mul_nzvc  = {w_acc_nxt[WIDTH-1], ~|w_acc_nxt[WIDTH-1:0], 1'b0, |w_acc_nxt[2*WIDTH-1:WIDTH]};

  // Shift-add: one multiplier bit per cycle, final partial sum feeds the output directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_fwen   <= 1'b0;
    end else if (w_start_mul) begin
      r_state  <= S_MULT;
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_a_sh};
      r_mplier <= operand_B;
      r_acc    <= '0;
      r_fwen   <= flag_wen;
    end else if (r_state == S_MULT) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_mul_done) r_state <= S_IDLE;
    end
  end
`else
  assign w_idle      = 1'b1;
  assign w_start_mul = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_mul_fwen  = 1'b0;
  assign w_mul_res   = '0;
  assign w_mul_nzvc  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      if (w_mul_fwen) r_flags <= w_mul_nzvc;
    end else if (w_accept && !w_start_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      if (flag_wen) r_flags <= w_nzvc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags_out = r_flags;
  assign busy      = ~w_idle;

endmodule
